rp_operand_checker: RTL and testbench
=====================================

# rp_operand_checker

Static-region driver and checker for the 4x4 multiplier reconfigurable partition: generates operand pairs on the partition's `in1`/`in2` inputs, controls the partition's synchronous reset, and compares the partition's registered 8-bit product against a locally computed expected value. Sits on the static side of the partition boundary. After each partial bitstream load, software or the debug VIO uses it to confirm that the loaded module behaves as a registered multiplier.

## Interface
Parameters:
- `LATENCY`, default 1: clock edges from an operand change at the partition input to the matching product on `rp_out`. Legal range 1–4.
- `RST_CYCLES`, default 4: number of cycles `rp_reset` is held high in the reset-check phase. Legal range 2–15.

Ports:
- `clk`, in, 1: single clock, shared with the partition.
- `reset_n`, in, 1: asynchronous, active-low reset of this block.
- `start`, in, 1: single-cycle pulse that begins a run. Ignored while `busy`.
- `mode`, in, 1: 0 runs one pair (`op_a`,`op_b`); 1 runs all 256 pairs exhaustively. Sampled on `start`.
- `op_a`, in, 4: operand A used in single mode. Sampled on `start`.
- `op_b`, in, 4: operand B used in single mode. Sampled on `start`.
- `rp_out`, in, 8: product from the partition.
- `in1`, out, 4: operand A to the partition (registered).
- `in2`, out, 4: operand B to the partition (registered).
- `rp_reset`, out, 1: active-high synchronous reset to the partition (registered).
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse at the end of a run.
- `pass`, out, 1: result of the last run; valid from `done` onward and held until the next `start`.
- `err_count`, out, 9: number of mismatches in the last run, saturating at 511.
- `fail_a`, out, 4: operand A of the first mismatch in the run.
- `fail_b`, out, 4: operand B of the first mismatch in the run.
- `fail_got`, out, 8: `rp_out` value at the first mismatch in the run.

## Operation
- FSM states: IDLE, RST_HOLD, RST_CHECK, DRIVE, DRAIN, FINISH.
- IDLE: all run outputs hold. A `start` pulse captures `mode`, `op_a` and `op_b`, clears `err_count` and the `fail_*` registers, and moves to RST_HOLD.
- RST_HOLD: `rp_reset`=1 for exactly `RST_CYCLES` cycles; `in1`/`in2`=0. Then go to RST_CHECK.
- RST_CHECK (one cycle, `rp_reset`=0): compare `rp_out` against 0x00.
  - A mismatch counts as an error and records `fail_a`=`fail_b`=0 with `fail_got`=`rp_out`.
  - Then go to DRIVE.
- DRIVE: present a new pair each cycle.
  - Single mode: one pair (`op_a`,`op_b`).
  - Exhaustive mode: pairs in order {a,b} = 0x00 … 0xFF, with `b` as the low nibble incrementing first.
  - After the last pair, go to DRAIN.
- Expected pipeline: each driven pair enters a shift register of depth `LATENCY`+1 holding (valid, a, b, a*b). The 8-bit product is an exact unsigned 4x4 multiply; the maximum is 15*15 = 225 = 0xE1.
- Compare rule: when a valid entry reaches the pipeline tail, compare it with `rp_out`.
  - Any mismatch increments `err_count`, saturating at 511.
  - `fail_*` record only the first mismatch.
- DRAIN: hold `in1`/`in2`, stop inserting valid entries, and wait until the pipeline is empty. Then go to FINISH.
- FINISH: pulse `done`, drop `busy`, set `pass` = (`err_count`==0), and return to IDLE.
- `start` while `busy` is ignored; the run continues unaffected.
- `reset_n` low at any time, including mid-run: state returns to IDLE immediately and the pipeline is cleared.

## Timing
- Reset values with `reset_n`=0:
  - `in1`=0, `in2`=0, `rp_reset`=1 (holds the partition in reset during this block's reset).
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0.
  - `fail_a`=0, `fail_b`=0, `fail_got`=0.
- After `reset_n` deasserts, `rp_reset` drops to 0 on the first `clk` edge.
- `start` sampled at edge E: `busy`=1 and `rp_reset`=1 from E+1, with `rp_reset` high for edges E+1 … E+`RST_CYCLES`.
- A pair driven at edge D is compared at edge D+`LATENCY`+1, i.e. the sample taken one cycle after the partition registers it.
- Run length:
  - Single mode: `done` at E+`RST_CYCLES`+`LATENCY`+4.
  - Exhaustive mode: 255 cycles later than single mode.
- Throughput in DRIVE: one pair per cycle, no stalls.

## Test plan
- Behavioural partition model (LATENCY=1, correct multiply); single mode, `op_a`=0xF, `op_b`=0xF -> `rp_out`=0xE1 checked; `done` at E+9 with default parameters; `pass`=1, `err_count`=0.
- Exhaustive mode against the correct model -> 256 compares, `pass`=1, `err_count`=0, `done` exactly 255 cycles later than in single mode.
- Model with `out` bit 7 stuck at 0; exhaustive mode -> `pass`=0. The first failure is `fail_a`=9, `fail_b`=0xF, `fail_got`=0x07 (9*15=0x87). `err_count` equals the number of products ≥ 0x80.
- Model that ignores `reset_vio` and powers up with `out`=0x5A -> RST_CHECK records an error: `fail_a`=0, `fail_b`=0, `fail_got`=0x5A, `pass`=0.
- `reset_n` pulsed low mid-way through an exhaustive run -> immediately `busy`=0, `rp_reset`=1, `err_count`=0. A following `start` completes normally with `pass`=1.
- `start` reasserted while `busy`, and LATENCY=3 with a 3-stage model -> the second `start` is ignored, `done` pulses exactly once, and compares stay aligned (`pass`=1).

Source files
------------

// File: rtl/rp_operand_checker.sv
// rtl/rp_operand_checker.sv - operand driver and product checker for the 4x4 multiplier partition
// Resets the partition, drives operand pairs and compares its registered product against a local model.
module rp_operand_checker #(
  parameter int LATENCY    = 1,
  parameter int RST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       mode,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic [7:0] rp_out,
  output logic [3:0] in1,
  output logic [3:0] in2,
  output logic       rp_reset,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [3:0] fail_a,
  output logic [3:0] fail_b,
  output logic [7:0] fail_got
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_HOLD, S_RST_CHECK, S_DRIVE, S_DRAIN, S_FINISH
  } state_t;

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
  localparam logic [8:0] ERR_MAX  = 9'h1FF;

  state_t state_q, state_d;
  logic       mode_q, mode_d;
  logic [3:0] opa_q, opa_d, opb_q, opb_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] pair_q, pair_d;
  logic [3:0] in1_q, in1_d, in2_q, in2_d;
  logic       rp_reset_q, rp_reset_d;
  logic       pass_q, pass_d;
  logic [8:0] err_q, err_d;
  logic [3:0] fa_q, fa_d, fb_q, fb_d;
  logic [7:0] fg_q, fg_d;

  // Expected-value pipeline; index LATENCY is the tail that lines up with rp_out.
  logic [LATENCY:0]      pv_q, pv_d;
  logic [LATENCY:0][3:0] pa_q, pa_d, pb_q, pb_d;
  logic [LATENCY:0][7:0] pp_q, pp_d;

  logic [3:0] cur_a, cur_b;
  logic       chk_en;
  logic [3:0] exp_a, exp_b;
  logic [7:0] exp_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_RST_HOLD;
      S_RST_HOLD:  if (cnt_q == RST_LAST) state_d = S_RST_CHECK;
      S_RST_CHECK: state_d = S_DRIVE;
      S_DRIVE:     if (!mode_q || pair_q == 8'hFF) state_d = S_DRAIN;
      S_DRAIN:     if (pv_q == '0) state_d = S_FINISH;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    pair_d     = pair_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fa_d       = fa_q;
    fb_d       = fb_q;
    fg_d       = fg_q;
    cnt_d      = (state_q == S_RST_HOLD) ? cnt_q + 4'd1 : 4'd0;
    rp_reset_d = (state_d == S_RST_HOLD);

    cur_a = mode_q ? pair_q[7:4] : opa_q;
    cur_b = mode_q ? pair_q[3:0] : opb_q;
    pv_d  = {pv_q[LATENCY-1:0], (state_q == S_DRIVE)};
    pa_d  = {pa_q[LATENCY-1:0], cur_a};
    pb_d  = {pb_q[LATENCY-1:0], cur_b};
    pp_d  = {pp_q[LATENCY-1:0], 8'({4'b0, cur_a} * {4'b0, cur_b})};

    if (state_q == S_DRIVE) begin
      in1_d  = cur_a;
      in2_d  = cur_b;
      pair_d = pair_q + 8'd1;
    end
    if (state_d == S_RST_HOLD) begin
      in1_d = 4'd0;
      in2_d = 4'd0;
    end

    // The reset check reuses the mismatch path with an all-zero expected entry.
    chk_en = (state_q == S_RST_CHECK) || pv_q[LATENCY];
    exp_a  = (state_q == S_RST_CHECK) ? 4'd0 : pa_q[LATENCY];
    exp_b  = (state_q == S_RST_CHECK) ? 4'd0 : pb_q[LATENCY];
    exp_p  = (state_q == S_RST_CHECK) ? 8'd0 : pp_q[LATENCY];
    if (chk_en && rp_out != exp_p) begin
      if (err_q != ERR_MAX) err_d = err_q + 9'd1;
      if (err_q == 9'd0) begin
        fa_d = exp_a;
        fb_d = exp_b;
        fg_d = rp_out;
      end
    end

    if (state_q == S_DRAIN && state_d == S_FINISH) pass_d = (err_q == 9'd0);

    if (state_q == S_IDLE && start) begin
      mode_d = mode;
      opa_d  = op_a;
      opb_d  = op_b;
      pair_d = 8'd0;
      pass_d = 1'b0;
      err_d  = 9'd0;
      fa_d   = 4'd0;
      fb_d   = 4'd0;
      fg_d   = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= 1'b0;
      opa_q      <= 4'd0;
      opb_q      <= 4'd0;
      cnt_q      <= 4'd0;
      pair_q     <= 8'd0;
      in1_q      <= 4'd0;
      in2_q      <= 4'd0;
      rp_reset_q <= 1'b1;
      pass_q     <= 1'b0;
      err_q      <= 9'd0;
      fa_q       <= 4'd0;
      fb_q       <= 4'd0;
      fg_q       <= 8'd0;
      pv_q       <= '0;
      pa_q       <= '0;
      pb_q       <= '0;
      pp_q       <= '0;
    end else begin
      mode_q     <= mode_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      cnt_q      <= cnt_d;
      pair_q     <= pair_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      rp_reset_q <= rp_reset_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      fg_q       <= fg_d;
      pv_q       <= pv_d;
      pa_q       <= pa_d;
      pb_q       <= pb_d;
      pp_q       <= pp_d;
    end
  end

  assign in1       = in1_q;
  assign in2       = in2_q;
  assign rp_reset  = rp_reset_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done      = (state_q == S_FINISH);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign fail_got  = fg_q;

endmodule

// File: tb/tb_rp_operand_checker.sv
// tb/tb_rp_operand_checker.sv - directed bench for rp_operand_checker with behavioural partition models
module tb_rp_operand_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, mode, sel, pu_load;
  logic [3:0] op_a, op_b;
  int         fault;
  int         errors = 0;
  int         checks = 0;

  logic       start1, start3;
  logic [7:0] rp_out1, rp_out3;
  logic [3:0] in1_1, in2_1, in1_3, in2_3;
  logic       rp_reset1, rp_reset3, busy1, busy3, done1, done3, pass1, pass3;
  logic [8:0] err1, err3;
  logic [3:0] fa1, fb1, fa3, fb3;
  logic [7:0] fg1, fg3;

  assign start1 = start & ~sel;
  assign start3 = start & sel;

  rp_operand_checker #(.LATENCY(1), .RST_CYCLES(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode), .op_a(op_a), .op_b(op_b),
    .rp_out(rp_out1), .in1(in1_1), .in2(in2_1), .rp_reset(rp_reset1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1), .fail_got(fg1)
  );

  rp_operand_checker #(.LATENCY(3), .RST_CYCLES(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .mode(mode), .op_a(op_a), .op_b(op_b),
    .rp_out(rp_out3), .in1(in1_3), .in2(in2_3), .rp_reset(rp_reset3), .busy(busy3),
    .done(done3), .pass(pass3), .err_count(err3), .fail_a(fa3), .fail_b(fb3), .fail_got(fg3)
  );

  // fault 1: product bit 7 stuck at 0; fault 2: reset treated as hold, power-up value 0x5A
  logic [7:0] m1, prod1, prod3, s1, s2, s3;
  assign prod1 = {4'b0, in1_1} * {4'b0, in2_1};
  assign prod3 = {4'b0, in1_3} * {4'b0, in2_3};
  always @(posedge clk) begin
    if (pu_load) m1 <= 8'h5A;
    else if (rp_reset1) begin
      if (fault != 2) m1 <= 8'h00;
    end else m1 <= (fault == 1) ? (prod1 & 8'h7F) : prod1;
  end
  assign rp_out1 = m1;

  always @(posedge clk) begin
    s1 <= rp_reset3 ? 8'h00 : prod3;
    s2 <= rp_reset3 ? 8'h00 : s1;
    s3 <= rp_reset3 ? 8'h00 : s2;
  end
  assign rp_out3 = s3;

  logic       busy_o, done_o, pass_o, rp_reset_o;
  logic [8:0] err_o;
  assign busy_o     = sel ? busy3 : busy1;
  assign done_o     = sel ? done3 : done1;
  assign pass_o     = sel ? pass3 : pass1;
  assign rp_reset_o = sel ? rp_reset3 : rp_reset1;
  assign err_o      = sel ? err3 : err1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cyc_done counts edges from the start-sampling edge E to the first edge after which done is seen
  task automatic run(input logic m, input logic [3:0] a, input logic [3:0] b, input bit restart,
                     output int cyc_done, output int npulse);
    int cyc;
    cyc = 0;
    cyc_done = 0;
    npulse = 0;
    @(negedge clk);
    mode = m; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; pu_load = 1'b0;
    mode = ~m; op_a = ~a; op_b = ~b;
    chk("busy_after_start", busy_o, 1);
    chk("rp_reset_after_start", rp_reset_o, 1);
    while (cyc < 2000 && !(cyc_done != 0 && cyc >= cyc_done + 6)) begin
      @(posedge clk);
      cyc++;
      #1;
      if (restart) start = (cyc == 3);
      if (done_o) begin
        npulse++;
        if (cyc_done == 0) cyc_done = cyc;
      end
    end
    chk("run_completed", 32'(cyc_done != 0), 1);
  endtask

  int cd, np;

  initial begin
    sel = 1'b0; fault = 0; pu_load = 1'b0; start = 1'b0;
    mode = 1'b0; op_a = 4'd0; op_b = 4'd0; reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in", {in1_1, in2_1}, 8'h00);
    chk("rst_rp_reset", rp_reset1, 1);
    chk("rst_flags", {busy1, done1, pass1}, 3'b000);
    chk("rst_err", err1, 0);
    chk("rst_fail", {fa1, fb1, fg1}, 16'h0000);

    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rp_reset_release", rp_reset1, 0);

    run(1'b0, 4'hF, 4'hF, 1'b0, cd, np);
    chk("single_done_cycle", cd, 9);
    chk("single_done_pulses", np, 1);
    chk("single_pass", pass1, 1);
    chk("single_err", err1, 0);
    chk("single_rp_out", rp_out1, 8'hE1);
    chk("single_in_hold", {in1_1, in2_1}, 8'hFF);

    run(1'b1, 4'h0, 4'h0, 1'b0, cd, np);
    chk("exh_done_cycle", cd, 264);
    chk("exh_pass", pass1, 1);
    chk("exh_err", err1, 0);

    fault = 1;
    run(1'b1, 4'h0, 4'h0, 1'b0, cd, np);
    chk("stuck_done_cycle", cd, 264);
    chk("stuck_pass", pass1, 0);
    chk("stuck_err", err1, 32);
    chk("stuck_fail_a", fa1, 4'h9);
    chk("stuck_fail_b", fb1, 4'hF);
    chk("stuck_fail_got", fg1, 8'h07);

    fault = 2;
    pu_load = 1'b1;
    run(1'b0, 4'h3, 4'h5, 1'b0, cd, np);
    chk("pwrup_pass", pass1, 0);
    chk("pwrup_err", err1, 1);
    chk("pwrup_fail", {fa1, fb1, fg1}, 16'h005A);

    fault = 0;
    @(negedge clk);
    mode = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_busy", busy1, 1);
    @(negedge clk) reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_rp_reset", rp_reset1, 1);
    chk("mid_rst_err", err1, 0);
    @(negedge clk) reset_n = 1'b1;
    run(1'b1, 4'h0, 4'h0, 1'b0, cd, np);
    chk("after_rst_done_cycle", cd, 264);
    chk("after_rst_pass", pass1, 1);

    sel = 1'b1;
    run(1'b0, 4'hF, 4'hF, 1'b1, cd, np);
    chk("lat3_single_done_cycle", cd, 11);
    chk("lat3_single_pulses", np, 1);
    chk("lat3_single_pass", pass3, 1);
    chk("lat3_single_err", err3, 0);

    run(1'b1, 4'h0, 4'h0, 1'b1, cd, np);
    chk("lat3_exh_done_cycle", cd, 266);
    chk("lat3_exh_pulses", np, 1);
    chk("lat3_exh_pass", pass3, 1);
    chk("lat3_exh_err", err3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
